traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Parametrised two-road intersection controller that drives two RYG lamp sets and one pedestrian lamp.
//  Fixed-time sequencing comes from an internal 1 s tick prescaler. Pedestrian requests are latched and
//  serviced during an all-red window. An asynchronous night input selects flashing yellow.
//  Sits directly between board pins (buttons/switch) and the on-board LEDs.
// PARAMETERS
//  TICK_CYCLES    27_000_000  sys_clk cycles per phase tick (1 s at 27 MHz); >= 2
//  GREEN_S        10          green duration, ticks; >= 1
//  YELLOW_S       3           yellow duration, ticks; >= 1
//  ALLRED_S       1           all-red clearance, ticks; >= 1
//  PED_S          8           pedestrian walk duration, ticks; >= 1
//  LED_ACTIVE_LOW 1           1: lamp outputs inverted (0 = lit); 0: active-high
// PORTS
//  sys_clk     in   1  clock
//  sys_rst_n   in   1  reset, asynchronous, active-low
//  ped_req     in   1  pedestrian button, asynchronous level/pulse
//  night_mode  in   1  night switch, asynchronous level
//  ped_ack     out  1  one-cycle pulse when a request is latched
//  led_a       out  3  road A lamps {R,Y,G}, polarity per LED_ACTIVE_LOW
//  led_b       out  3  road B lamps {R,Y,G}
//  ped_walk    out  1  walk lamp, polarity per LED_ACTIVE_LOW
//  state_o     out  3  current state code (debug)
// BEHAVIOUR
//  - ped_req and night_mode each pass through a 2-flop synchroniser; all references below use the synced values.
//  - States: ALL_RED=0, A_GREEN=1, A_YELLOW=2, B_GREEN=3, B_YELLOW=4, PED_WALK=5, NIGHT=6.
//  - Prescaler runs 0..TICK_CYCLES-1. tick=1 for one cycle at TICK_CYCLES-1.
//  - Prescaler and sec_cnt are cleared on every state change.
//  - Every non-NIGHT phase therefore lasts exactly DUR*TICK_CYCLES cycles.
//  - On tick: if sec_cnt==DUR-1, transition; else sec_cnt+1. Width: $clog2 of max(param)+1.
//  - Sequence: ALL_RED -> (next_b ? B_GREEN : A_GREEN); A_GREEN->A_YELLOW->ALL_RED(next_b=1);
//    B_GREEN->B_YELLOW->ALL_RED(next_b=0).
//  - ALL_RED expiry with ped_pending=1 -> PED_WALK. This clears ped_pending and holds next_b.
//    PED_WALK expiry -> green selected by next_b (no second all-red).
//  - ped_pending sets on synced ped_req=1. ped_ack=1 for exactly the cycle after pending goes 0->1.
//  - A request while pending is already set causes no ack.
//  - A request during PED_WALK re-latches after the clear and is served at the next ALL_RED.
//  - When ped_req set and PED_WALK entry coincide, the clear wins; the request re-latches next cycle.
//  - night=1 forces NIGHT from any state on the next edge; ped_pending is kept.
//  - In NIGHT both Y lamps toggle on each tick, starting lit; all other lamps are off.
//  - night=0 while in NIGHT -> ALL_RED with next_b=0.
//  - Lamps are decoded combinationally from the registered state; there is no extra latency.
//    ALL_RED: both R. A_GREEN: A.G + B.R. A_YELLOW: A.Y + B.R. B_* mirrored.
//    PED_WALK: both R + walk.
//  - Reset (async, any time): state=ALL_RED, next_b=0, all counters 0, pending=0, ped_ack=0.
//    Outputs immediately show both R lit and walk off (led_a=led_b=3'b011 when active-low).
// TESTING  (TICK_CYCLES=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1, PED_S=2, LED_ACTIVE_LOW=1)
//  1. Release reset, no inputs -> ALL_RED 4, A_GREEN 12, A_YELLOW 8, ALL_RED 4, B_GREEN 12, B_YELLOW 8 cycles.
//     Period is 48 cycles; led_a=110 during A_GREEN.
//  2. 1-cycle ped_req pulse in A_GREEN -> ped_ack pulse 3 cycles later (sync + latch).
//     After A_YELLOW: ALL_RED 4, PED_WALK 8 (ped_walk=0), then B_GREEN.
//  3. ped_req held high across PED_WALK -> exactly two acks; second walk after B_YELLOW's ALL_RED, then A_GREEN.
//  4. night_mode=1 mid B_GREEN -> NIGHT 2 cycles after sync; led_a=led_b alternate 101/111 every 4 cycles.
//     night_mode=0 -> ALL_RED 4 cycles, then A_GREEN.
//  5. Assert sys_rst_n=0 mid A_YELLOW with ped_pending=1 -> led_a=led_b=011 same cycle.
//     After release: no PED_WALK, A_GREEN after 4 cycles.
//  6. LED_ACTIVE_LOW=0, repeat test 1 -> all lamp outputs bitwise inverted; timing identical.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-road fixed-time intersection controller with pedestrian walk phase
// and a flashing-yellow night mode. Lamps are decoded straight from the
// state register so they change on the same edge as the state.
module traffic_light_ctrl #(
  parameter int TICK_CYCLES    = 27_000_000,
  parameter int GREEN_S        = 10,
  parameter int YELLOW_S       = 3,
  parameter int ALLRED_S       = 1,
  parameter int PED_S          = 8,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       ped_ack,
  output logic [2:0] led_a,
  output logic [2:0] led_b,
  output logic       ped_walk,
  output logic [2:0] state_o
);

  localparam int MAX_AB = (GREEN_S > YELLOW_S) ? GREEN_S : YELLOW_S;
  localparam int MAX_CD = (ALLRED_S > PED_S) ? ALLRED_S : PED_S;
  localparam int MAX_D  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int SEC_W  = $clog2(MAX_D + 1);
  localparam int PW     = $clog2(TICK_CYCLES);
  localparam logic POL  = (LED_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    ST_ALL_RED  = 3'd0,
    ST_A_GREEN  = 3'd1,
    ST_A_YELLOW = 3'd2,
    ST_B_GREEN  = 3'd3,
    ST_B_YELLOW = 3'd4,
    ST_PED_WALK = 3'd5,
    ST_NIGHT    = 3'd6
  } state_t;

  state_t           state;
  logic             next_b;
  logic [PW-1:0]    presc;
  logic [SEC_W-1:0] sec_cnt;
  logic [SEC_W-1:0] dur_m1;
  logic             ped_s1, ped_s2, night_s1, night_s2;
  logic             ped_pending;
  logic             y_on;
  logic             tick;
  logic             expire;
  logic             walk_entry;
  logic [2:0]       lamp_a, lamp_b;
  logic             lamp_w;

  // Bring the asynchronous board inputs into the sys_clk domain
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ped_s1   <= 1'b0;
      ped_s2   <= 1'b0;
      night_s1 <= 1'b0;
      night_s2 <= 1'b0;
    end else begin
      ped_s1   <= ped_req;
      ped_s2   <= ped_s1;
      night_s1 <= night_mode;
      night_s2 <= night_s1;
    end
  end

  // Phase length (minus one) in ticks for the current state
  always_comb begin
    dur_m1 = SEC_W'(ALLRED_S - 1);
    case (state)
      ST_A_GREEN, ST_B_GREEN:   dur_m1 = SEC_W'(GREEN_S - 1);
      ST_A_YELLOW, ST_B_YELLOW: dur_m1 = SEC_W'(YELLOW_S - 1);
      ST_PED_WALK:              dur_m1 = SEC_W'(PED_S - 1);
      default:                  dur_m1 = SEC_W'(ALLRED_S - 1);
    endcase
  end

  assign tick       = (presc == PW'(TICK_CYCLES - 1));
  assign expire     = tick && (sec_cnt == dur_m1);
  // Night entry pre-empts any transition, so a walk can only start without it
  assign walk_entry = (state == ST_ALL_RED) && !night_s2 && expire && ped_pending;

  // Phase sequencer; counters restart on every state change
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_ALL_RED;
      next_b  <= 1'b0;
      presc   <= '0;
      sec_cnt <= '0;
      y_on    <= 1'b1;
    end else if (night_s2 && state != ST_NIGHT) begin
      state   <= ST_NIGHT;
      presc   <= '0;
      sec_cnt <= '0;
      y_on    <= 1'b1;
    end else if (state == ST_NIGHT) begin
      if (!night_s2) begin
        state   <= ST_ALL_RED;
        next_b  <= 1'b0;
        presc   <= '0;
        sec_cnt <= '0;
      end else if (tick) begin
        presc <= '0;
        y_on  <= ~y_on;
      end else begin
        presc <= presc + 1'b1;
      end
    end else if (tick) begin
      presc <= '0;
      if (expire) begin
        sec_cnt <= '0;
        case (state)
          ST_ALL_RED:  state <= ped_pending ? ST_PED_WALK
                               : (next_b ? ST_B_GREEN : ST_A_GREEN);
          ST_A_GREEN:  state <= ST_A_YELLOW;
          ST_A_YELLOW: begin state <= ST_ALL_RED; next_b <= 1'b1; end
          ST_B_GREEN:  state <= ST_B_YELLOW;
          ST_B_YELLOW: begin state <= ST_ALL_RED; next_b <= 1'b0; end
          ST_PED_WALK: state <= next_b ? ST_B_GREEN : ST_A_GREEN;
          default:     state <= ST_ALL_RED;
        endcase
      end else begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Pedestrian request latch; walk entry clears it and wins over a new request
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      ped_pending <= walk_entry ? 1'b0 : (ped_pending | ped_s2);
      ped_ack     <= !walk_entry && ped_s2 && !ped_pending;
    end
  end

  // Lamp decode, active-high {R,Y,G}
  always_comb begin
    lamp_a = 3'b100;
    lamp_b = 3'b100;
    lamp_w = 1'b0;
    case (state)
      ST_A_GREEN:  lamp_a = 3'b001;
      ST_A_YELLOW: lamp_a = 3'b010;
      ST_B_GREEN:  lamp_b = 3'b001;
      ST_B_YELLOW: lamp_b = 3'b010;
      ST_PED_WALK: lamp_w = 1'b1;
      ST_NIGHT: begin
        lamp_a = {1'b0, y_on, 1'b0};
        lamp_b = {1'b0, y_on, 1'b0};
      end
      default: ;
    endcase
  end

  assign led_a    = lamp_a ^ {3{POL}};
  assign led_b    = lamp_b ^ {3{POL}};
  assign ped_walk = lamp_w ^ POL;
  assign state_o  = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench: a phase/countdown model of the intersection is compared
// every cycle against an active-low and an active-high instance, and a set
// of hand-computed timeline points pins the model.
module tb_traffic_light_ctrl;

  localparam int T = 4, GS = 3, YS = 2, AS = 1, PS = 2;
  localparam int AR = 0, AG = 1, AY = 2, BG = 3, BY = 4, PW = 5, NT = 6;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, ped_req = 1'b0, night_mode = 1'b0;
  logic ack_lo, ack_hi, walk_lo, walk_hi;
  logic [2:0] la_lo, lb_lo, st_lo, la_hi, lb_hi, st_hi;

  int checks = 0, failures = 0, k = 0, ack_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  traffic_light_ctrl #(.TICK_CYCLES(T), .GREEN_S(GS), .YELLOW_S(YS), .ALLRED_S(AS),
                       .PED_S(PS), .LED_ACTIVE_LOW(1)) u_lo (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ped_req(ped_req), .night_mode(night_mode),
    .ped_ack(ack_lo), .led_a(la_lo), .led_b(lb_lo), .ped_walk(walk_lo), .state_o(st_lo));

  traffic_light_ctrl #(.TICK_CYCLES(T), .GREEN_S(GS), .YELLOW_S(YS), .ALLRED_S(AS),
                       .PED_S(PS), .LED_ACTIVE_LOW(0)) u_hi (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ped_req(ped_req), .night_mode(night_mode),
    .ped_ack(ack_hi), .led_a(la_hi), .led_b(lb_hi), .ped_walk(walk_hi), .state_o(st_hi));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  // ---------------- behavioural model: phase + cycles left ----------------
  int   m_ph, m_left, m_nleft;
  logic m_nextb, m_pend, m_ack, m_y, ms1, ms2, mn1, mn2;

  function automatic int phase_cycles(input int ph);
    case (ph)
      AG, BG:  return GS * T;
      AY, BY:  return YS * T;
      PW:      return PS * T;
      default: return AS * T;
    endcase
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin : model
    int ph, left, nleft;
    logic nb, y, walk, pend;
    if (!sys_rst_n) begin
      m_ph <= AR; m_left <= AS * T; m_nleft <= T; m_nextb <= 1'b0;
      m_pend <= 1'b0; m_ack <= 1'b0; m_y <= 1'b1;
      ms1 <= 1'b0; ms2 <= 1'b0; mn1 <= 1'b0; mn2 <= 1'b0;
    end else begin
      ph = m_ph; left = m_left; nleft = m_nleft; nb = m_nextb; y = m_y; walk = 1'b0;
      if (mn2 && ph != NT) begin
        ph = NT; nleft = T; y = 1'b1;
      end else if (ph == NT) begin
        if (!mn2) begin ph = AR; left = AS * T; nb = 1'b0; end
        else begin
          nleft--;
          if (nleft == 0) begin y = !y; nleft = T; end
        end
      end else begin
        left--;
        if (left == 0) begin
          case (ph)
            AR: if (m_pend) begin ph = PW; walk = 1'b1; end else ph = nb ? BG : AG;
            AG: ph = AY;
            AY: begin ph = AR; nb = 1'b1; end
            BG: ph = BY;
            BY: begin ph = AR; nb = 1'b0; end
            default: ph = nb ? BG : AG;
          endcase
          left = phase_cycles(ph);
        end
      end
      pend = walk ? 1'b0 : (m_pend | ms2);
      m_ack <= pend && !m_pend;
      m_pend <= pend;
      m_ph <= ph; m_left <= left; m_nleft <= nleft; m_nextb <= nb; m_y <= y;
      ms1 <= ped_req; ms2 <= ms1; mn1 <= night_mode; mn2 <= mn1;
    end
  end

  function automatic logic [2:0] exp_lamp(input int ph, input logic y, input bit road_b);
    if (ph == NT) return {1'b0, y, 1'b0};
    if (!road_b && ph == AG) return 3'b001;
    if (!road_b && ph == AY) return 3'b010;
    if (road_b && ph == BG) return 3'b001;
    if (road_b && ph == BY) return 3'b010;
    return 3'b100;
  endfunction

  // Every-cycle comparison of both instances against the model
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      chk("state_lo", {5'd0, st_lo}, 8'(m_ph));
      chk("state_hi", {5'd0, st_hi}, 8'(m_ph));
      chk("led_a_lo", {5'd0, la_lo}, {5'd0, ~exp_lamp(m_ph, m_y, 1'b0)});
      chk("led_b_lo", {5'd0, lb_lo}, {5'd0, ~exp_lamp(m_ph, m_y, 1'b1)});
      chk("led_a_hi", {5'd0, la_hi}, {5'd0, exp_lamp(m_ph, m_y, 1'b0)});
      chk("led_b_hi", {5'd0, lb_hi}, {5'd0, exp_lamp(m_ph, m_y, 1'b1)});
      chk("walk_lo", {7'd0, walk_lo}, {7'd0, !(m_ph == PW)});
      chk("walk_hi", {7'd0, walk_hi}, {7'd0, (m_ph == PW)});
      chk("ack_lo", {7'd0, ack_lo}, {7'd0, m_ack});
      chk("ack_hi", {7'd0, ack_hi}, {7'd0, m_ack});
      if (ack_lo) ack_cnt++;
    end
  end

  // Advance to negedge number n after reset release
  task automatic go(input int n);
    while (k < n) begin @(negedge sys_clk); k++; end
  endtask

  task automatic drive(input logic p, input logic n);
    #1; ped_req = p; night_mode = n;
  endtask

  initial begin
    int a0;
    // Reset state, outputs immediate
    #2;
    chk("rst_led_a", {5'd0, la_lo}, 8'b011);
    chk("rst_led_b", {5'd0, lb_lo}, 8'b011);
    chk("rst_walk", {7'd0, walk_lo}, 8'd1);
    chk("rst_led_a_hi", {5'd0, la_hi}, 8'b100);
    @(negedge sys_clk); #1; sys_rst_n = 1'b1; k = 0;

    // 1. free-running cycle
    go(3);  chk("t1_ar", {5'd0, st_lo}, 8'd0);
    go(4);  chk("t1_ag", {5'd0, st_lo}, 8'd1);
            chk("t1_ag_leda", {5'd0, la_lo}, 8'b110);
            chk("t1_ag_ledb", {5'd0, lb_lo}, 8'b011);
            chk("t1_ag_leda_hi", {5'd0, la_hi}, 8'b001);
    go(15); chk("t1_ag_end", {5'd0, st_lo}, 8'd1);
    go(16); chk("t1_ay", {5'd0, st_lo}, 8'd2);
            chk("t1_ay_leda", {5'd0, la_lo}, 8'b101);
    go(24); chk("t1_ar2", {5'd0, st_lo}, 8'd0);
    go(28); chk("t1_bg", {5'd0, st_lo}, 8'd3);
            chk("t1_bg_ledb", {5'd0, lb_lo}, 8'b110);
    go(40); chk("t1_by", {5'd0, st_lo}, 8'd4);
    go(48); chk("t1_period", {5'd0, st_lo}, 8'd0);

    // 2. single ped pulse in A_GREEN
    go(54); drive(1'b1, 1'b0);
    go(55); drive(1'b0, 1'b0);
    go(56); chk("t2_noack", {7'd0, ack_lo}, 8'd0);
    go(57); chk("t2_ack", {7'd0, ack_lo}, 8'd1);
    go(58); chk("t2_ack_once", {7'd0, ack_lo}, 8'd0);
    go(72); chk("t2_ar", {5'd0, st_lo}, 8'd0);
    go(76); chk("t2_walk", {5'd0, st_lo}, 8'd5);
            chk("t2_walk_lamp", {7'd0, walk_lo}, 8'd0);
    go(83); chk("t2_walk_end", {5'd0, st_lo}, 8'd5);
    go(84); chk("t2_bg", {5'd0, st_lo}, 8'd3);

    // 3. ped_req held across a walk phase
    go(110); a0 = ack_cnt; drive(1'b1, 1'b0);
    go(132); chk("t3_walk1", {5'd0, st_lo}, 8'd5);
    go(134); drive(1'b0, 1'b0);
    go(140); chk("t3_bg", {5'd0, st_lo}, 8'd3);
             chk("t3_two_acks", 8'(ack_cnt - a0), 8'd2);
    go(164); chk("t3_walk2", {5'd0, st_lo}, 8'd5);
    go(172); chk("t3_ag", {5'd0, st_lo}, 8'd1);

    // 4. night mode mid B_GREEN
    go(200); drive(1'b0, 1'b1);
    go(202); chk("t4_pre", {5'd0, st_lo}, 8'd3);
    go(203); chk("t4_night", {5'd0, st_lo}, 8'd6);
             chk("t4_y_on_a", {5'd0, la_lo}, 8'b101);
             chk("t4_y_on_b", {5'd0, lb_lo}, 8'b101);
    go(206); chk("t4_y_on_end", {5'd0, la_lo}, 8'b101);
    go(207); chk("t4_y_off", {5'd0, la_lo}, 8'b111);
    go(211); chk("t4_y_on2", {5'd0, lb_lo}, 8'b101);
    go(212); drive(1'b0, 1'b0);
    go(214); chk("t4_still", {5'd0, st_lo}, 8'd6);
    go(215); chk("t4_ar", {5'd0, st_lo}, 8'd0);
    go(219); chk("t4_ag", {5'd0, st_lo}, 8'd1);

    // 5. reset mid A_YELLOW with a pending request
    go(221); drive(1'b1, 1'b0);
    go(222); drive(1'b0, 1'b0);
    go(233); chk("t5_ay", {5'd0, st_lo}, 8'd2);
    #2; sys_rst_n = 1'b0; #1;
    chk("t5_rst_a", {5'd0, la_lo}, 8'b011);
    chk("t5_rst_b", {5'd0, lb_lo}, 8'b011);
    chk("t5_rst_st", {5'd0, st_lo}, 8'd0);
    @(negedge sys_clk); #1; sys_rst_n = 1'b1; k = 0;
    go(3); chk("t5_ar", {5'd0, st_lo}, 8'd0);
    go(4); chk("t5_ag_nowalk", {5'd0, st_lo}, 8'd1);
    go(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
